// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL loop controller: state encoding, sign tracking
// codes, default widths and small integer saturation helpers.
package adpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } adpll_state_e;

    // Sign of the previous nonzero phase-error sample seen in ACQUIRE.
    localparam logic [1:0] PS_NONE = 2'b00;
    localparam logic [1:0] PS_POS  = 2'b01;
    localparam logic [1:0] PS_NEG  = 2'b10;

    localparam int DEF_CTRL_WIDTH = 5;
    localparam int DEF_PDET_WIDTH = 8;
    localparam int DEF_INT_WIDTH  = 12;
    localparam int DEF_FRAC_BITS  = 4;

    function automatic int sat_s(input int x, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic int clamp_u(input int x, input int w);
        int hi;
        hi = (1 << w) - 1;
        if (x > hi) return hi;
        if (x < 0)  return 0;
        return x;
    endfunction

    function automatic int abs_s(input int x);
        return (x < 0) ? -x : x;
    endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Lock qualification: counts consecutive in-window samples in TRACK and flags
// loss of lock in LOCKED using a wider unlock window for hysteresis.
module adpll_lock_detect
    import adpll_pkg::*;
#(
    parameter int PDET_WIDTH    = 8,
    parameter int LOCK_THRESH   = 2,
    parameter int UNLOCK_THRESH = 8,
    parameter int LOCK_COUNT    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                sample_i,
    input  adpll_state_e        mode_i,
    input  logic [PDET_WIDTH:0] abs_err_i,
    output logic                lock_req_o,
    output logic                unlock_req_o
);

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(LOCK_COUNT);
    localparam logic [PDET_WIDTH:0] LOCK_T   = (PDET_WIDTH + 1)'(LOCK_THRESH);
    localparam logic [PDET_WIDTH:0] UNLOCK_T = (PDET_WIDTH + 1)'(UNLOCK_THRESH);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_window;
    logic             out_hyst;

    assign in_window = (abs_err_i <= LOCK_T);
    assign out_hyst  = (abs_err_i > UNLOCK_T);

    always_comb begin
        cnt_d        = cnt_q;
        lock_req_o   = 1'b0;
        unlock_req_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (sample_i) begin
            case (mode_i)
                ST_TRACK: begin
                    if (in_window) begin
                        // Counter pins at LOCK_COUNT instead of wrapping.
                        if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
                        lock_req_o = (cnt_q >= CNT_MAX - 1'b1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (out_hyst) begin
                        unlock_req_o = 1'b1;
                        cnt_d        = '0;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: saturating integral filter with ACQUIRE/TRACK gain switching,
// lock detection and ring-oscillator frequency-select mapping. ADPLL_PROP_PATH_EN adds a proportional path.
module adpll_loop_ctrl
    import adpll_pkg::*;
#(
    parameter int CTRL_WIDTH    = DEF_CTRL_WIDTH,
    parameter int PDET_WIDTH    = DEF_PDET_WIDTH,
    parameter int INT_WIDTH     = DEF_INT_WIDTH,
    parameter int FRAC_BITS     = DEF_FRAC_BITS,
    parameter int BIAS          = 16,
    parameter int ACQ_SHIFT     = 0,
    parameter int TRK_SHIFT     = 2,
    parameter int LOCK_THRESH   = 2,
    parameter int UNLOCK_THRESH = 8,
    parameter int LOCK_COUNT    = 16,
    parameter int KP_SHIFT      = 1
) (
    input  logic                         fpga_clk_i,
    input  logic                         reset_n_i,
    input  logic                         enable_i,
    input  logic signed [PDET_WIDTH-1:0] error_i,
    input  logic                         error_valid_i,
    output logic        [CTRL_WIDTH-1:0] freq_sel_o,
    output logic signed [CTRL_WIDTH-1:0] dco_cc_o,
    output logic                         locked_o,
    output logic                         lost_lock_o,
    output logic                         [1:0] state_o
);

    if (INT_WIDTH < CTRL_WIDTH + FRAC_BITS) begin : g_bad_int_width
        $error("INT_WIDTH must be at least CTRL_WIDTH+FRAC_BITS");
    end
    if (KP_SHIFT < 0 || KP_SHIFT >= PDET_WIDTH) begin : g_bad_kp_shift
        $error("KP_SHIFT out of range");
    end

    adpll_state_e                 state_q;
    logic signed [INT_WIDTH-1:0]  integ_q, integ_d;
    logic signed [CTRL_WIDTH-1:0] dco_cc_q, dco_cc_d;
    logic        [CTRL_WIDTH-1:0] freq_sel_q, freq_sel_d;
    logic        [1:0]            prev_sign_q;
    logic                         locked_q;
    logic                         lost_lock_q;

    logic [PDET_WIDTH:0] abs_err;
    logic                err_zero;
    logic                err_neg;
    logic                sign_flip;
    logic                lock_req;
    logic                unlock_req;

    int step_n;
    int integ_n;
    int dco_raw;
    int dco_n;
    int freq_n;
    int abs_n;

    // Filter datapath evaluated in plain integers; all parameterised widths fit well within 32 bits.
    always_comb begin
        step_n = (state_q == ST_ACQUIRE) ? (int'(error_i) >>> ACQ_SHIFT)
                                         : (int'(error_i) >>> TRK_SHIFT);
        integ_n = sat_s(int'(integ_q) + step_n, INT_WIDTH);
        dco_raw = integ_n >>> FRAC_BITS;
`ifdef ADPLL_PROP_PATH_EN
        dco_raw = dco_raw + (int'(error_i) >>> KP_SHIFT);
`endif
        dco_n   = sat_s(dco_raw, CTRL_WIDTH);
        freq_n  = clamp_u(BIAS - dco_n, CTRL_WIDTH);
        abs_n   = abs_s(int'(error_i));

        integ_d    = INT_WIDTH'(integ_n);
        dco_cc_d   = CTRL_WIDTH'(dco_n);
        freq_sel_d = CTRL_WIDTH'(freq_n);
        abs_err    = (PDET_WIDTH + 1)'(abs_n);
    end

    assign err_zero  = (error_i == '0);
    assign err_neg   = error_i[PDET_WIDTH-1];
    assign sign_flip = ((prev_sign_q == PS_POS) && err_neg) ||
                       ((prev_sign_q == PS_NEG) && !err_neg && !err_zero);

    adpll_lock_detect #(
        .PDET_WIDTH   (PDET_WIDTH),
        .LOCK_THRESH  (LOCK_THRESH),
        .UNLOCK_THRESH(UNLOCK_THRESH),
        .LOCK_COUNT   (LOCK_COUNT)
    ) u_lock_detect (
        .clk_i       (fpga_clk_i),
        .rst_ni      (reset_n_i),
        .clear_i     (!enable_i),
        .sample_i    (error_valid_i),
        .mode_i      (state_q),
        .abs_err_i   (abs_err),
        .lock_req_o  (lock_req),
        .unlock_req_o(unlock_req)
    );

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            integ_q     <= '0;
            dco_cc_q    <= '0;
            freq_sel_q  <= CTRL_WIDTH'(BIAS);
            prev_sign_q <= PS_NONE;
            locked_q    <= 1'b0;
            lost_lock_q <= 1'b0;
        end else if (!enable_i) begin
            state_q     <= ST_IDLE;
            integ_q     <= '0;
            dco_cc_q    <= '0;
            freq_sel_q  <= CTRL_WIDTH'(BIAS);
            prev_sign_q <= PS_NONE;
            locked_q    <= 1'b0;
            lost_lock_q <= 1'b0;
        end else begin
            lost_lock_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                state_q <= ST_ACQUIRE;
            end else if (error_valid_i) begin
                integ_q    <= integ_d;
                dco_cc_q   <= dco_cc_d;
                freq_sel_q <= freq_sel_d;
                case (state_q)
                    ST_ACQUIRE: begin
                        if (err_zero || sign_flip) state_q <= ST_TRACK;
                        if (!err_zero) prev_sign_q <= err_neg ? PS_NEG : PS_POS;
                    end
                    ST_TRACK: begin
                        if (lock_req) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (unlock_req) begin
                            state_q     <= ST_TRACK;
                            locked_q    <= 1'b0;
                            lost_lock_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign freq_sel_o  = freq_sel_q;
    assign dco_cc_o    = dco_cc_q;
    assign locked_o    = locked_q;
    assign lost_lock_o = lost_lock_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Self-checking bench for adpll_loop_ctrl: table vectors, corner-case sequences and
// randomized traffic against an arithmetic reference model.
module tb_adpll_loop_ctrl;

    localparam int CW    = 5;
    localparam int PW    = 8;
    localparam int IW    = 12;
    localparam int FB    = 4;
    localparam int BIAS  = 16;
    localparam int ACQ   = 0;
    localparam int TRK   = 2;
    localparam int LT    = 2;
    localparam int UT    = 8;
    localparam int LC    = 16;
    localparam int KP    = 1;

    logic                 clk;
    logic                 reset_n;
    logic                 enable;
    logic signed [PW-1:0] err_in;
    logic                 err_vld;
    logic        [CW-1:0] freq_sel;
    logic signed [CW-1:0] dco_cc;
    logic                 locked;
    logic                 lost_lock;
    logic        [1:0]    state;

    int n_vec;
    int n_mis;

    // Reference model state (state numbers: 0 idle, 1 acquire, 2 track, 3 locked).
    int m_state, m_integ, m_cnt, m_prev, m_dco, m_freq, m_locked, m_lost;

    adpll_loop_ctrl dut (
        .fpga_clk_i   (clk),
        .reset_n_i    (reset_n),
        .enable_i     (enable),
        .error_i      (err_in),
        .error_valid_i(err_vld),
        .freq_sel_o   (freq_sel),
        .dco_cc_o     (dco_cc),
        .locked_o     (locked),
        .lost_lock_o  (lost_lock),
        .state_o      (state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    function automatic int floor_div2(input int v, input int sh);
        int d;
        d = 1 << sh;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic m_reset();
        m_state = 0; m_integ = 0; m_cnt = 0; m_prev = 0;
        m_dco = 0; m_freq = BIAS; m_locked = 0; m_lost = 0;
    endtask

    task automatic m_step(input bit en, input int e, input bit vld);
        int sgn, a;
        m_lost = 0;
        if (!en) begin
            m_reset();
            return;
        end
        if (m_state == 0) begin
            m_state = 1;
            return;
        end
        if (!vld) return;
        m_integ = clamp(m_integ + floor_div2(e, (m_state == 1) ? ACQ : TRK),
                        -(1 << (IW - 1)), (1 << (IW - 1)) - 1);
        m_dco = floor_div2(m_integ, FB);
`ifdef ADPLL_PROP_PATH_EN
        m_dco = m_dco + floor_div2(e, KP);
`endif
        m_dco  = clamp(m_dco, -(1 << (CW - 1)), (1 << (CW - 1)) - 1);
        m_freq = clamp(BIAS - m_dco, 0, (1 << CW) - 1);
        sgn = (e > 0) ? 1 : ((e < 0) ? -1 : 0);
        a   = (e < 0) ? -e : e;
        if (m_state == 1) begin
            if (e == 0 || (m_prev != 0 && sgn == -m_prev)) m_state = 2;
            if (e != 0) m_prev = sgn;
        end else if (m_state == 2) begin
            if (a <= LT) begin
                m_cnt = (m_cnt < LC) ? m_cnt + 1 : LC;
                if (m_cnt == LC) m_state = 3;
            end else begin
                m_cnt = 0;
            end
        end else if (a > UT) begin
            m_state = 2;
            m_cnt   = 0;
            m_lost  = 1;
        end
        m_locked = (m_state == 3) ? 1 : 0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".state"},  int'(state),     m_state);
        check({tag, ".dco"},    int'(dco_cc),    m_dco);
        check({tag, ".freq"},   int'(freq_sel),  m_freq);
        check({tag, ".locked"}, int'(locked),    m_locked);
        check({tag, ".lost"},   int'(lost_lock), m_lost);
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input bit en, input int e, input bit vld, input string tag);
        @(negedge clk);
        enable  = en;
        err_in  = PW'(e);
        err_vld = vld;
        @(posedge clk);
        m_step(en, e, vld);
        #1;
        check_model(tag);
    endtask

    task automatic go_track();
        cyc(1'b0, 0, 1'b0, "gt_idle");
        cyc(1'b1, 0, 1'b0, "gt_acq");
        cyc(1'b1, 0, 1'b1, "gt_trk");
        check("go_track.state", int'(state), 2);
    endtask

    typedef struct {
        bit en;
        int err;
        bit vld;
        int st;
        int dco;
        int freq;
        int lk;
    } vec_t;

    vec_t tbl[8];

    initial begin
        n_vec = 0;
        n_mis = 0;
        m_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        err_in  = '0;
        err_vld = 1'b0;

        // Reset / idle, then acquisition gain and the ACQUIRE->TRACK sign change.
        tbl[0] = '{1'b0,  50, 1'b1, 0, 0, 16, 0};
        tbl[1] = '{1'b0,  50, 1'b1, 0, 0, 16, 0};
        tbl[2] = '{1'b1,   0, 1'b0, 1, 0, 16, 0};
        tbl[3] = '{1'b1,  16, 1'b1, 1, 1, 15, 0};
        tbl[4] = '{1'b1,  16, 1'b1, 1, 2, 14, 0};
        tbl[5] = '{1'b1,  16, 1'b1, 1, 3, 13, 0};
        tbl[6] = '{1'b1,  -4, 1'b1, 2, 2, 14, 0};
        tbl[7] = '{1'b1,  99, 1'b0, 2, 2, 14, 0};

        #12;
        check("rst.state", int'(state), 0);
        check("rst.freq",  int'(freq_sel), 16);
        check("rst.dco",   int'(dco_cc), 0);
        check("rst.locked", int'(locked), 0);
        check("rst.lost",  int'(lost_lock), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].en, tbl[i].err, tbl[i].vld, "tbl");
            check($sformatf("tbl%0d.state", i),  int'(state),    tbl[i].st);
            check($sformatf("tbl%0d.dco", i),    int'(dco_cc),   tbl[i].dco);
            check($sformatf("tbl%0d.freq", i),   int'(freq_sel), tbl[i].freq);
            check($sformatf("tbl%0d.locked", i), int'(locked),   tbl[i].lk);
        end

        // Lock after 16 in-window samples, then hysteresis and unlock.
        go_track();
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1, 1'b1, "lock");
            if (i == 15) check("lock.pre_state", int'(state), 2);
        end
        check("lock.state", int'(state), 3);
        check("lock.locked", int'(locked), 1);
        cyc(1'b1, 8, 1'b1, "hyst");
        check("hyst.state", int'(state), 3);
        cyc(1'b1, 9, 1'b1, "unlock");
        check("unlock.state", int'(state), 2);
        check("unlock.lost", int'(lost_lock), 1);
        check("unlock.locked", int'(locked), 0);
        cyc(1'b1, 0, 1'b0, "unlock_after");
        check("unlock.lost_pulse", int'(lost_lock), 0);

        // Out-of-window sample at position 10 restarts the count.
        go_track();
        for (int i = 1; i <= 26; i++) begin
            cyc(1'b1, (i == 10) ? -3 : 1, 1'b1, "relock");
            if (i == 25) check("relock.pre_state", int'(state), 2);
        end
        check("relock.state", int'(state), 3);

        // Enable drop while locked, with a coincident strobe.
        cyc(1'b0, 50, 1'b1, "drop");
        check("drop.state", int'(state), 0);
        check("drop.freq", int'(freq_sel), 16);
        check("drop.locked", int'(locked), 0);
        check("drop.dco", int'(dco_cc), 0);

        // Integrator and output saturation in ACQUIRE.
        cyc(1'b1, 0, 1'b0, "sat_acq");
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, -128, 1'b1, "sat");
            if (i == 16 || i == 20) begin
                check("sat.state", int'(state), 1);
                check("sat.dco", int'(dco_cc), -16);
                check("sat.freq", int'(freq_sel), 31);
            end
        end

        // Proportional path contribution from TRACK with an empty integrator.
        go_track();
        cyc(1'b1, 8, 1'b1, "prop");
`ifdef ADPLL_PROP_PATH_EN
        check("prop.dco", int'(dco_cc), 4);
        check("prop.freq", int'(freq_sel), 12);
`else
        check("prop.dco", int'(dco_cc), 0);
        check("prop.freq", int'(freq_sel), 16);
`endif

        // Randomized traffic, weighted towards small errors so lock is reached.
        for (int i = 0; i < 4000; i++) begin
            int sel, e;
            bit en, vld;
            sel = int'($urandom_range(0, 7));
            if (sel < 5)       e = int'($urandom_range(0, 4)) - 2;
            else if (sel == 5) e = int'($urandom_range(0, 20)) - 10;
            else if (sel == 6) e = int'($urandom_range(0, 255)) - 128;
            else               e = 0;
            en  = ($urandom_range(0, 299) != 0);
            vld = ($urandom_range(0, 3) != 0);
            cyc(en, e, vld, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
